// File: rtl/ref_level_scheduler_if.sv
// Control/status bundle between the reference-level scheduler and its host.
// The host drives run/symbol/config requests; the scheduler returns the
// generator controls and averaging status.
interface ref_level_scheduler_if #(
    parameter int unsigned MAX_LOG2_M = 20,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned LOG2_W     = 5
);
    logic                  enable;
    logic                  sym_ena;
    logic                  cfg_load;
    logic [LOG2_W-1:0]     log2_m_req;
    logic                  clear_accumulator;
    logic [MAX_LOG2_M:0]   MSamples;
    logic [7:0]            shiftVal;
    logic                  window_done;
    logic                  ref_valid;
    logic                  cfg_busy;
    logic [CNT_W-1:0]      window_count;

    modport master (
        output enable, sym_ena, cfg_load, log2_m_req,
        input  clear_accumulator, MSamples, shiftVal, window_done,
               ref_valid, cfg_busy, window_count
    );

    modport slave (
        input  enable, sym_ena, cfg_load, log2_m_req,
        output clear_accumulator, MSamples, shiftVal, window_done,
               ref_valid, cfg_busy, window_count
    );
endinterface

// File: rtl/ref_level_scheduler.sv
// Reference-level averaging scheduler for the 16QAM receiver.
// Frames 2^log2_m-symbol averaging windows on symbol strobes, drives the
// generator's clear/length/shift controls, defers averaging-length changes to
// window boundaries and reports when the reference level has settled.
module ref_level_scheduler #(
    parameter int unsigned MAX_LOG2_M     = 20,
    parameter int unsigned RESET_LOG2_M   = 10,
    parameter int unsigned SETTLE_WINDOWS = 1,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned LOG2_W         = 5
) (
    input logic                   clk,
    input logic                   reset,
    ref_level_scheduler_if.slave  bus
);

    localparam int unsigned MW = MAX_LOG2_M + 1;
    localparam int unsigned SW = $clog2(SETTLE_WINDOWS + 2);
    localparam logic [SW-1:0]     SETTLE_SAT = SW'(SETTLE_WINDOWS + 1);
    localparam logic [LOG2_W-1:0] LOG2_MAX   = LOG2_W'(MAX_LOG2_M);
    localparam logic [LOG2_W-1:0] LOG2_RST   = LOG2_W'(RESET_LOG2_M);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DUMP
    } state_t;

    state_t              state_q, state_n;
    logic [MW-1:0]       sym_cnt_q, sym_cnt_n;
    logic [SW-1:0]       settle_q, settle_n;
    logic [LOG2_W-1:0]   log2_m_q, log2_m_n;
    logic [LOG2_W-1:0]   pending_q, pending_n;
    logic                cfg_busy_q, cfg_busy_n;
    logic                window_done_q, window_done_n;
    logic                ref_valid_q, ref_valid_n;
    logic [CNT_W-1:0]    window_count_q, window_count_n;
    logic                clear_q, clear_n;
    logic [MW-1:0]       msamples_q, msamples_n;
    logic [7:0]          shift_q, shift_n;

    logic                apply;
    logic [MW-1:0]       last_cnt;
    logic [LOG2_W-1:0]   req_clamped;

    assign last_cnt    = msamples_q - MW'(1);
    assign req_clamped = (bus.log2_m_req > LOG2_MAX) ? LOG2_MAX : bus.log2_m_req;

    // Next-state, window framing, config apply and settle tracking.
    always_comb begin
        state_n        = state_q;
        sym_cnt_n      = sym_cnt_q;
        settle_n       = settle_q;
        log2_m_n       = log2_m_q;
        pending_n      = pending_q;
        cfg_busy_n     = cfg_busy_q;
        window_done_n  = 1'b0;
        ref_valid_n    = ref_valid_q;
        window_count_n = window_count_q;

        // Outside a running window a pending config takes effect at once;
        // inside one it waits for the DUMP strobe so shiftVal stays stable
        // across the clear rise and the next window starts clean.
        apply = cfg_busy_q &&
                ((state_q == IDLE) || (state_q == CLEAR) ||
                 ((state_q == DUMP) && bus.enable && bus.sym_ena));

        // Settled one clock after the window that saturates the settle count.
        if (window_done_q && (settle_q == SETTLE_SAT))
            ref_valid_n = 1'b1;

        if (!bus.enable) begin
            state_n     = IDLE;
            sym_cnt_n   = '0;
            settle_n    = '0;
            ref_valid_n = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_n  = CLEAR;
                    settle_n = '0;
                end
                CLEAR: begin
                    if (bus.sym_ena) begin
                        state_n   = ACCUM;
                        sym_cnt_n = '0;
                    end
                end
                ACCUM: begin
                    if (bus.sym_ena) begin
                        if (sym_cnt_q == last_cnt) begin
                            state_n        = DUMP;
                            window_done_n  = 1'b1;
                            window_count_n = window_count_q + CNT_W'(1);
                            if (settle_q != SETTLE_SAT)
                                settle_n = settle_q + SW'(1);
                        end else begin
                            sym_cnt_n = sym_cnt_q + MW'(1);
                        end
                    end
                end
                DUMP: begin
                    if (bus.sym_ena) begin
                        state_n   = ACCUM;
                        sym_cnt_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (apply) begin
            log2_m_n    = pending_q;
            cfg_busy_n  = 1'b0;
            ref_valid_n = 1'b0;
            settle_n    = '0;
        end

        // A load coinciding with an apply stays pending for the next boundary.
        if (bus.cfg_load) begin
            pending_n  = req_clamped;
            cfg_busy_n = 1'b1;
        end

        clear_n    = (state_n == CLEAR) || (state_n == DUMP);
        msamples_n = MW'(1) << log2_m_n;
        shift_n    = 8'(log2_m_n);
    end

    // State and registered outputs with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            sym_cnt_q      <= '0;
            settle_q       <= '0;
            log2_m_q       <= LOG2_RST;
            pending_q      <= LOG2_RST;
            cfg_busy_q     <= 1'b0;
            window_done_q  <= 1'b0;
            ref_valid_q    <= 1'b0;
            window_count_q <= '0;
            clear_q        <= 1'b0;
            msamples_q     <= MW'(1) << LOG2_RST;
            shift_q        <= 8'(LOG2_RST);
        end else begin
            state_q        <= state_n;
            sym_cnt_q      <= sym_cnt_n;
            settle_q       <= settle_n;
            log2_m_q       <= log2_m_n;
            pending_q      <= pending_n;
            cfg_busy_q     <= cfg_busy_n;
            window_done_q  <= window_done_n;
            ref_valid_q    <= ref_valid_n;
            window_count_q <= window_count_n;
            clear_q        <= clear_n;
            msamples_q     <= msamples_n;
            shift_q        <= shift_n;
        end
    end

    assign bus.clear_accumulator = clear_q;
    assign bus.MSamples          = msamples_q;
    assign bus.shiftVal          = shift_q;
    assign bus.window_done       = window_done_q;
    assign bus.ref_valid         = ref_valid_q;
    assign bus.cfg_busy          = cfg_busy_q;
    assign bus.window_count      = window_count_q;

endmodule

// File: tb/tb_ref_level_scheduler.sv
// Bench for ref_level_scheduler: config table, directed multi-window
// sequences and a randomized run against a strobe-counting reference model.
module tb_ref_level_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b0;

    ref_level_scheduler_if #(.MAX_LOG2_M(20), .CNT_W(16), .LOG2_W(5)) bus ();

    ref_level_scheduler #(
        .MAX_LOG2_M(20),
        .RESET_LOG2_M(10),
        .SETTLE_WINDOWS(1),
        .CNT_W(16),
        .LOG2_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int strobe_num = 0;
    int wd_at[$];

    // Reference model: run flag, clear phase and accumulated strobe count.
    bit          m_run, m_clearing, m_first, m_busy, m_valid, m_wd;
    int          m_acc, m_log2, m_pend, m_settle;
    logic [15:0] m_wcount;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_run = 0; m_clearing = 0; m_first = 0; m_busy = 0; m_valid = 0; m_wd = 0;
        m_acc = 0; m_log2 = 10; m_pend = 10; m_settle = 0; m_wcount = '0;
    endfunction

    function automatic void model_step(input bit en, input bit se, input bit ld, input logic [4:0] req);
        bit apply;
        bit set_valid;
        apply = m_busy && (!m_run || (m_clearing && m_first) || (en && se && m_clearing && !m_first));
        set_valid = m_wd && (m_settle == 2);
        m_wd = 0;
        if (!en) begin
            m_run = 0; m_clearing = 0; m_acc = 0; m_settle = 0; m_valid = 0;
        end else begin
            if (set_valid) m_valid = 1;
            if (!m_run) begin
                m_run = 1; m_clearing = 1; m_first = 1; m_settle = 0;
            end else if (se) begin
                if (m_clearing) begin
                    m_clearing = 0; m_acc = 0;
                end else begin
                    m_acc++;
                    if (m_acc == (1 << m_log2)) begin
                        m_wd = 1; m_wcount++; m_clearing = 1; m_first = 0;
                        if (m_settle < 2) m_settle++;
                    end
                end
            end
        end
        if (apply) begin
            m_log2 = m_pend; m_busy = 0; m_valid = 0; m_settle = 0;
        end
        if (ld) begin
            m_pend = (int'(req) > 20) ? 20 : int'(req);
            m_busy = 1;
        end
    endfunction

    function automatic void compare_all();
        chk("clear_accumulator", 32'(bus.clear_accumulator), 32'(m_run && m_clearing));
        chk("MSamples", 32'(bus.MSamples), 32'(1) << m_log2);
        chk("shiftVal", 32'(bus.shiftVal), 32'(m_log2));
        chk("window_done", 32'(bus.window_done), 32'(m_wd));
        chk("ref_valid", 32'(bus.ref_valid), 32'(m_valid));
        chk("cfg_busy", 32'(bus.cfg_busy), 32'(m_busy));
        chk("window_count", 32'(bus.window_count), 32'(m_wcount));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) model_reset();
        else model_step(bus.enable, bus.sym_ena, bus.cfg_load, bus.log2_m_req);
        compare_all();
        if (bus.window_done === 1'b1) wd_at.push_back(strobe_num);
    endtask

    task automatic strobe();
        bus.sym_ena = 1'b1;
        strobe_num++;
        tick();
        bus.sym_ena = 1'b0;
        repeat (3) tick();
    endtask

    task automatic load_cfg(input logic [4:0] req);
        bus.cfg_load   = 1'b1;
        bus.log2_m_req = req;
        tick();
        bus.cfg_load   = 1'b0;
    endtask

    task automatic run_to_wd(input int limit);
        int n0;
        int k;
        n0 = wd_at.size();
        k = 0;
        while (wd_at.size() == n0 && k < limit) begin
            strobe();
            k++;
        end
        chk("windows_completed", 32'(wd_at.size() - n0), 32'd1);
    endtask

    typedef struct {
        logic [4:0]  req;
        logic [20:0] ms;
        logic [7:0]  sh;
    } cfg_vec_t;

    cfg_vec_t tbl [6];

    initial begin
        int base;
        tbl[0] = '{req: 5'd31, ms: 21'd1048576, sh: 8'd20};
        tbl[1] = '{req: 5'd0,  ms: 21'd1,       sh: 8'd0};
        tbl[2] = '{req: 5'd21, ms: 21'd1048576, sh: 8'd20};
        tbl[3] = '{req: 5'd20, ms: 21'd1048576, sh: 8'd20};
        tbl[4] = '{req: 5'd7,  ms: 21'd128,     sh: 8'd7};
        tbl[5] = '{req: 5'd2,  ms: 21'd4,       sh: 8'd2};

        bus.enable = 1'b0; bus.sym_ena = 1'b0; bus.cfg_load = 1'b0; bus.log2_m_req = '0;

        // Asynchronous reset, checked before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("rst_clear", 32'(bus.clear_accumulator), 32'd0);
        chk("rst_MSamples", 32'(bus.MSamples), 32'd1024);
        chk("rst_shiftVal", 32'(bus.shiftVal), 32'd10);
        chk("rst_window_count", 32'(bus.window_count), 32'd0);
        chk("rst_ref_valid", 32'(bus.ref_valid), 32'd0);
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Config clamp / apply table (applied from IDLE).
        foreach (tbl[i]) begin
            load_cfg(tbl[i].req);
            chk("tbl_busy_set", 32'(bus.cfg_busy), 32'd1);
            tick();
            chk("tbl_MSamples", 32'(bus.MSamples), 32'(tbl[i].ms));
            chk("tbl_shiftVal", 32'(bus.shiftVal), 32'(tbl[i].sh));
            chk("tbl_busy_clr", 32'(bus.cfg_busy), 32'd0);
        end

        // Windows of 4 with a strobe every 4 clocks.
        strobe_num = 0;
        wd_at.delete();
        bus.enable = 1'b1;
        tick();
        chk("t1_clear_before_first", 32'(bus.clear_accumulator), 32'd1);
        repeat (2) tick();
        strobe();
        chk("t1_clear_after_first", 32'(bus.clear_accumulator), 32'd0);
        repeat (4) strobe();
        chk("t1_valid_after_w1", 32'(bus.ref_valid), 32'd0);
        repeat (5) strobe();
        chk("t1_valid_after_w2", 32'(bus.ref_valid), 32'd1);
        repeat (5) strobe();
        chk("t1_wd_count", 32'(wd_at.size()), 32'd3);
        if (wd_at.size() >= 3) begin
            chk("t1_wd1_strobe", 32'(wd_at[0]), 32'd5);
            chk("t1_wd2_strobe", 32'(wd_at[1]), 32'd10);
            chk("t1_wd3_strobe", 32'(wd_at[2]), 32'd15);
        end
        chk("t1_window_count", 32'(bus.window_count), 32'd3);

        // Mid-window reconfig to 3: applied only on the DUMP strobe.
        repeat (3) strobe();
        load_cfg(5'd3);
        repeat (2) strobe();
        chk("t3_wd_strobe", 32'(wd_at[$]), 32'd20);
        chk("t3_clear_in_dump", 32'(bus.clear_accumulator), 32'd1);
        chk("t3_shift_held", 32'(bus.shiftVal), 32'd2);
        chk("t3_busy_held", 32'(bus.cfg_busy), 32'd1);
        strobe();
        chk("t3_shift_new", 32'(bus.shiftVal), 32'd3);
        chk("t3_MSamples_new", 32'(bus.MSamples), 32'd8);
        chk("t3_valid_dropped", 32'(bus.ref_valid), 32'd0);
        run_to_wd(20);
        chk("t3_wd_8strobes", 32'(wd_at[$]), 32'd29);
        chk("t3_valid_still_low", 32'(bus.ref_valid), 32'd0);
        run_to_wd(20);
        chk("t3_wd_next", 32'(wd_at[$]), 32'd38);
        chk("t3_valid_recovered", 32'(bus.ref_valid), 32'd1);

        // Disable mid-window, then re-enable into a full window.
        repeat (3) strobe();
        bus.enable = 1'b0;
        tick();
        chk("t5_clear_off", 32'(bus.clear_accumulator), 32'd0);
        chk("t5_valid_off", 32'(bus.ref_valid), 32'd0);
        tick();
        bus.enable = 1'b1;
        tick();
        chk("t5_clear_restart", 32'(bus.clear_accumulator), 32'd1);
        base = strobe_num;
        run_to_wd(20);
        chk("t5_full_window", 32'(wd_at[$] - base), 32'd9);

        // Two loads in one window: last one wins.
        repeat (3) strobe();
        load_cfg(5'd5);
        strobe();
        load_cfg(5'd6);
        chk("t4_busy_pending", 32'(bus.cfg_busy), 32'd1);
        chk("t4_shift_old", 32'(bus.shiftVal), 32'd3);
        run_to_wd(10);
        chk("t4_shift_at_wd", 32'(bus.shiftVal), 32'd3);
        strobe();
        chk("t4_shift_applied", 32'(bus.shiftVal), 32'd6);
        chk("t4_MSamples_applied", 32'(bus.MSamples), 32'd64);
        chk("t4_busy_cleared", 32'(bus.cfg_busy), 32'd0);

        // Reset asserted mid-DUMP takes effect without a clock edge.
        run_to_wd(80);
        chk("t6_in_dump", 32'(bus.clear_accumulator), 32'd1);
        reset = 1'b1;
        #2;
        chk("t6_clear", 32'(bus.clear_accumulator), 32'd0);
        chk("t6_window_done", 32'(bus.window_done), 32'd0);
        chk("t6_MSamples", 32'(bus.MSamples), 32'd1024);
        chk("t6_shiftVal", 32'(bus.shiftVal), 32'd10);
        chk("t6_window_count", 32'(bus.window_count), 32'd0);
        chk("t6_ref_valid", 32'(bus.ref_valid), 32'd0);
        chk("t6_cfg_busy", 32'(bus.cfg_busy), 32'd0);
        model_reset();
        tick();
        reset = 1'b0;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 63) == 0) bus.enable = ~bus.enable;
            bus.sym_ena  = 1'($urandom_range(0, 1));
            bus.cfg_load = ($urandom_range(0, 31) == 0);
            bus.log2_m_req = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            tick();
        end
        bus.cfg_load = 1'b0;
        bus.sym_ena  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
